// File: rtl/controlador_pkg.sv
// Shared types, defaults and helpers for the music controller.
package controlador_pkg;

  typedef enum logic [1:0] {
    PARADO      = 2'd0,
    TOCANDO     = 2'd1,
    PAUSA_TROCA = 2'd2
  } estado_t;

  localparam int DEBOUNCE_CICLOS_PAD = 1000000;
  localparam int GAP_CICLOS_PAD      = 5000000;
  localparam int NUM_MUSICAS         = 4;
  localparam int NUM_BOTOES          = 2;
  localparam int BTN_PLAY            = 0;
  localparam int BTN_PROX            = 1;

  // Counter width that never collapses to zero bits for tiny parameters.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [NUM_MUSICAS-1:0] onehot(input logic [1:0] idx);
    logic [NUM_MUSICAS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/controlador_de_musica_if.sv
// Button/song-block side of the music controller.
interface controlador_de_musica_if;
  import controlador_pkg::*;

  logic                   botao_prox;
  logic                   botao_play;
  logic [NUM_MUSICAS-1:0] fim_msc;
  logic [1:0]             selecao;
  logic [NUM_MUSICAS-1:0] habilita_msc;
  logic                   reinicia_msc;
  logic                   tocando;
  logic                   mudo;

  modport master (
    output botao_prox, botao_play, fim_msc,
    input  selecao, habilita_msc, reinicia_msc, tocando, mudo
  );

  modport slave (
    input  botao_prox, botao_play, fim_msc,
    output selecao, habilita_msc, reinicia_msc, tocando, mudo
  );

endinterface

// File: rtl/controlador_de_musica_debouncer_botao.sv
// Active-low pushbutton: 2-FF sync, debounce, one pulse per accepted press.
module debouncer_botao
  import controlador_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PAD
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic botao_n,
  output logic evento
);

  localparam int CW = largura(DEBOUNCE_CICLOS);

  logic [1:0]    sinc_q, sinc_d;
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic          nivel_q, nivel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armado_q, armado_d;
  logic          evento_q, evento_d;

  always_comb begin
    sinc_d     = {sinc_q[0], botao_n};
    vld_pipe_d = {vld_pipe_q[0], 1'b1};
    nivel_d    = nivel_q;
    cnt_d      = '0;
    if (sinc_q[1] != nivel_q) begin
      if (cnt_q == CW'(DEBOUNCE_CICLOS - 1)) nivel_d = sinc_q[1];
      else                                   cnt_d   = cnt_q + 1'b1;
    end
    // Only a release seen after reset arms the button, so a press held
    // through reset stays silent until it is let go and pressed again.
    armado_d = armado_q | (vld_pipe_q[1] & sinc_q[1]);
    evento_d = armado_q & nivel_q & ~nivel_d;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sinc_q     <= 2'b11;
      vld_pipe_q <= '0;
      nivel_q    <= 1'b1;
      cnt_q      <= '0;
      armado_q   <= 1'b0;
      evento_q   <= 1'b0;
    end else begin
      sinc_q     <= sinc_d;
      vld_pipe_q <= vld_pipe_d;
      nivel_q    <= nivel_d;
      cnt_q      <= cnt_d;
      armado_q   <= armado_d;
      evento_q   <= evento_d;
    end
  end

  assign evento = evento_q;

endmodule

// File: rtl/controlador_de_musica.sv
// Play/stop and next-track sequencer for four song blocks with a silent gap
// between tracks.
module controlador_de_musica
  import controlador_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PAD,
  parameter int GAP_CICLOS      = GAP_CICLOS_PAD
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  controlador_de_musica_if.slave  bus
);

  localparam int GW = largura(GAP_CICLOS);

  logic [NUM_BOTOES-1:0]  botoes_n;
  logic [NUM_BOTOES-1:0]  eventos;
  estado_t                estado_q, estado_d;
  logic [1:0]             selecao_q, selecao_d;
  logic [NUM_MUSICAS-1:0] habilita_q, habilita_d;
  logic                   reinicia_q, reinicia_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   ev_play, ev_prox, fim;

  assign botoes_n[BTN_PLAY] = bus.botao_play;
  assign botoes_n[BTN_PROX] = bus.botao_prox;

  debouncer_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb [NUM_BOTOES-1:0] (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .botao_n  (botoes_n),
    .evento   (eventos)
  );

  assign ev_play = eventos[BTN_PLAY];
  assign ev_prox = eventos[BTN_PROX];
  assign fim     = bus.fim_msc[selecao_q];

  // Priority everywhere: play, then next, then end-of-song.
  always_comb begin
    estado_d   = estado_q;
    selecao_d  = selecao_q;
    habilita_d = habilita_q;
    reinicia_d = 1'b0;
    gap_d      = gap_q;
    case (estado_q)
      PARADO: begin
        habilita_d = '0;
        if (ev_play) begin
          estado_d   = TOCANDO;
          habilita_d = onehot(selecao_q);
          reinicia_d = 1'b1;
        end else if (ev_prox) begin
          selecao_d = selecao_q + 2'd1;
        end
      end
      TOCANDO: begin
        if (ev_play) begin
          estado_d   = PARADO;
          habilita_d = '0;
        end else if (ev_prox || fim) begin
          estado_d   = PAUSA_TROCA;
          selecao_d  = selecao_q + 2'd1;
          habilita_d = '0;
          gap_d      = GW'(GAP_CICLOS - 1);
        end
      end
      PAUSA_TROCA: begin
        habilita_d = '0;
        if (ev_play) begin
          estado_d = PARADO;
          gap_d    = '0;
        end else if (ev_prox) begin
          selecao_d = selecao_q + 2'd1;
          gap_d     = GW'(GAP_CICLOS - 1);
        end else if (gap_q == '0) begin
          estado_d   = TOCANDO;
          habilita_d = onehot(selecao_q);
          reinicia_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        estado_d   = PARADO;
        habilita_d = '0;
        gap_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= PARADO;
      selecao_q  <= '0;
      habilita_q <= '0;
      reinicia_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      selecao_q  <= selecao_d;
      habilita_q <= habilita_d;
      reinicia_q <= reinicia_d;
      gap_q      <= gap_d;
    end
  end

  assign bus.selecao      = selecao_q;
  assign bus.habilita_msc = habilita_q;
  assign bus.reinicia_msc = reinicia_q;
  assign bus.tocando      = (estado_q == TOCANDO);
  assign bus.mudo         = ~|habilita_q;

endmodule
